// File: rtl/alu_stream_pkg.sv
// Shared opcodes, FSM state encoding and the sign-aware compare helper
// used by alu_stream and alu_core.
package alu_stream_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_MIN    = 4'b0100;
  localparam logic [3:0] OP_MINALL = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Operands are zero-extended into this width by the caller; WIDTH must not exceed it.
  localparam int CMP_W = 64;

  // x < y over the low w bits. A signed order equals the unsigned order
  // once the sign bits are inverted, so one comparator serves both modes.
  function automatic logic is_less(input logic [CMP_W-1:0] x,
                                   input logic [CMP_W-1:0] y,
                                   input int               w,
                                   input logic             sgn);
    logic [CMP_W-1:0] flip;
    flip = sgn ? (CMP_W'(1) << (w - 1)) : '0;
    return (x ^ flip) < (y ^ flip);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ADD/XOR/MIN datapath with unsupported-opcode flag; shared
// by first beats and by the MINALL accumulate path (a = accumulator).
module alu_core
  import alu_stream_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ins,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err
);

  logic [WIDTH:0] sum;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    case (ins)
      OP_ADD: {carry, result} = sum;
      OP_XOR: result = a ^ b;
      // Ties keep a, so the earlier element wins.
      OP_MIN: result = is_less(CMP_W'(b), CMP_W'(a), WIDTH, SIGNED) ? b : a;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_stream.sv
// Handshaked ALU: registered pairwise ops plus a multi-beat MINALL reduction
// returning the minimum and the index of its first occurrence.
//
//   state    | meaning
//   ST_IDLE  | no result pending, waiting for a first beat
//   ST_ACCUM | MINALL stream in progress, accumulator holds running min
//   ST_HOLD  | result presented on out_*, waiting for out_ready
module alu_stream
  import alu_stream_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ins,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_carry,
  output logic             out_err
);

  // Pre-increment count of the beat that brings the count to 2^CNT_W-1.
  localparam logic [CNT_W-1:0] CNT_TRUNC = {{(CNT_W-1){1'b1}}, 1'b0};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CNT_W-1:0] out_idx_nxt;
  logic             carry_nxt;
  logic             err_nxt;

  logic [WIDTH-1:0] core_a;
  logic [3:0]       core_ins;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_err;
  logic             take_b;
  logic             accept;

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  // MINALL reuses the pairwise MIN; during a stream operand A is the accumulator.
  assign core_a   = (state == ST_ACCUM) ? acc : in_a;
  assign core_ins = ((state == ST_ACCUM) || (in_ins == OP_MINALL)) ? OP_MIN : in_ins;
  assign take_b   = is_less(CMP_W'(in_b), CMP_W'(core_a), WIDTH, SIGNED);

  alu_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a      (core_a),
    .b      (in_b),
    .ins    (core_ins),
    .result (core_res),
    .carry  (core_carry),
    .err    (core_err)
  );

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    data_nxt    = out_data;
    out_idx_nxt = out_idx;
    carry_nxt   = out_carry;
    err_nxt     = out_err;
    case (state)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_nxt = core_res;
          idx_nxt = take_b ? (cnt + CNT_W'(1)) : idx;
          cnt_nxt = cnt + CNT_W'(1);
          if (in_last || (cnt == CNT_TRUNC)) begin
            state_nxt   = ST_HOLD;
            data_nxt    = core_res;
            out_idx_nxt = idx_nxt;
            carry_nxt   = 1'b0;
            err_nxt     = ~in_last;
            acc_nxt     = '0;
            idx_nxt     = '0;
            cnt_nxt     = '0;
          end
        end
      end
      ST_IDLE, ST_HOLD: begin
        if ((state == ST_HOLD) && out_ready) state_nxt = ST_IDLE;
        // A first beat is also taken from HOLD in the cycle the result drains.
        if (accept) begin
          if ((in_ins == OP_MINALL) && !in_last) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = core_res;
            idx_nxt   = take_b ? CNT_W'(1) : '0;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt   = ST_HOLD;
            data_nxt    = core_res;
            carry_nxt   = core_carry;
            err_nxt     = core_err;
            out_idx_nxt = ((in_ins == OP_MINALL) && take_b) ? CNT_W'(1) : '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      idx       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      out_data  <= data_nxt;
      out_idx   <= out_idx_nxt;
      out_carry <= carry_nxt;
      out_err   <= err_nxt;
    end
  end

endmodule
